i2c_regfile: RTL and testbench



---
 rtl/i2c_regfile_if.sv | 17 +
 rtl/i2c_regfile.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_regfile.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_regfile_if.sv
// Purpose : parallel strobe bundle between the I2C slave byte engine and its register bank.
// Latency : none, wires only; dout is driven combinationally by the register bank.
// Backpr. : none; the byte engine paces all transfers and the bank never stalls it.
// Signals : act (addressed), as (pointer byte strobe), ws (write byte strobe),
//           rs (read byte strobe), din (byte from engine), dout (byte to engine).
// Modports: master = byte engine side, slave = register bank side.
interface i2c_regfile_if;
  logic       act;
  logic       as;
  logic       ws;
  logic       rs;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output act, output as, output ws, output rs, output din, input dout);
  modport slave  (input act, input as, input ws, input rs, input din, output dout);
endinterface

// File: rtl/i2c_regfile.sv
// Purpose : I2C-addressed register bank with auto-incrementing pointer and application write port.
// Latency : dout is combinational (0 cycles); wr_stb/rd_stb/idx_out 1 cycle; regs_out 1 cycle behind regs.
// Backpr. : none; every strobe is consumed in the cycle it is presented.
// Ports   : clk, rst (sync, active-high); i_bus (i2c_regfile_if.slave: act/as/ws/rs/din in, dout out);
//           i_hw_we/i_hw_addr/i_hw_wdata application write; o_regs_out live contents (flattened);
//           o_wr_stb/o_rd_stb/o_idx_out access strobes; o_err_cnt saturating rejected-access count.
// Option  : define I2C_REGFILE_SNAPSHOT_EN to read through a shadow copy taken at act rise and on as.
module i2c_regfile #(
  parameter int                     NREGS   = 8,
  parameter logic [8*NREGS-1:0]     RST_VAL = {NREGS{8'h00}},
  parameter logic [NREGS-1:0]       RO_MASK = {NREGS{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_regfile_if.slave         i_bus,
  input  logic                 i_hw_we,
  input  logic [7:0]           i_hw_addr,
  input  logic [7:0]           i_hw_wdata,
  output logic [8*NREGS-1:0]   o_regs_out,
  output logic                 o_wr_stb,
  output logic                 o_rd_stb,
  output logic [7:0]           o_idx_out,
  output logic [7:0]           o_err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PTR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_act_q;
  logic [7:0]         r_ptr;
  logic [8*NREGS-1:0] r_regs;
  logic [8*NREGS-1:0] r_regs_out;
  logic               r_wr_stb;
  logic               r_rd_stb;
  logic [7:0]         r_idx;
  logic [7:0]         r_err_cnt;

  logic               w_act_rise;
  logic               w_multi;
  logic [8*NREGS-1:0] w_rd_src;
  logic [7:0]         w_sel_dat;
  logic               w_sel_ro;
  logic               w_sel_hit;
  logic               w_ptr_load;
  logic               w_i2c_wr;
  logic               w_i2c_rd;
  logic               w_wr_ok;
  logic               w_err;

  assign w_act_rise = i_bus.act & ~r_act_q;
  assign w_multi    = (i_bus.as & i_bus.ws) | (i_bus.as & i_bus.rs) | (i_bus.ws & i_bus.rs);

`ifdef I2C_REGFILE_SNAPSHOT_EN
  // Shadow copy frozen at the start of each transfer so a multi-byte read
  // sees one consistent image even if the application updates registers.
  logic [8*NREGS-1:0] r_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= RST_VAL;
    end else if (w_act_rise || i_bus.as) begin
      r_shadow <= r_regs;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if (w_wr_ok && (r_ptr == 8'(k))) begin
          r_shadow[8*k +: 8] <= i_bus.din;
        end
      end
    end
  end

  assign w_rd_src = r_shadow;
`else
  assign w_rd_src = r_regs;
`endif

  // Pointer decode by comparison rather than indexing, so any NREGS up to
  // 256 works and an out-of-range pointer simply fails to hit.
  always_comb begin
    w_sel_dat = 8'hFF;
    w_sel_ro  = 1'b0;
    w_sel_hit = 1'b0;
    for (int k = 0; k < NREGS; k++) begin
      if (r_ptr == 8'(k)) begin
        w_sel_dat = w_rd_src[8*k +: 8];
        w_sel_ro  = RO_MASK[k];
        w_sel_hit = 1'b1;
      end
    end
  end

  assign i_bus.dout = w_sel_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_load  = 1'b0;
    w_i2c_wr    = 1'b0;
    w_i2c_rd    = 1'b0;
    w_err       = 1'b0;
    if (!i_bus.act) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_act_rise) begin
            w_state_nxt = ST_PTR;
          end
        end
        ST_PTR: begin
          // A data byte before any pointer byte has nowhere to go.
          if (i_bus.as) begin
            w_ptr_load  = 1'b1;
            w_state_nxt = ST_DATA;
          end else if (i_bus.ws) begin
            w_err = 1'b1;
          end else if (i_bus.rs) begin
            w_i2c_rd = 1'b1;
          end
          if (w_multi) begin
            w_err = 1'b1;
          end
        end
        ST_DATA: begin
          if (i_bus.as) begin
            w_ptr_load = 1'b1;
          end else if (i_bus.ws) begin
            w_i2c_wr = 1'b1;
          end else if (i_bus.rs) begin
            w_i2c_rd = 1'b1;
          end
          if (w_multi) begin
            w_err = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
    if (w_i2c_rd && !w_sel_hit) begin
      w_err = 1'b1;
    end
    if (w_i2c_wr && (!w_sel_hit || w_sel_ro)) begin
      w_err = 1'b1;
    end
  end

  assign w_wr_ok = w_i2c_wr & w_sel_hit & ~w_sel_ro;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_q    <= 1'b0;
      r_ptr      <= 8'h00;
      r_regs     <= RST_VAL;
      r_regs_out <= RST_VAL;
      r_wr_stb   <= 1'b0;
      r_rd_stb   <= 1'b0;
      r_idx      <= 8'h00;
      r_err_cnt  <= 8'h00;
    end else begin
      r_act_q    <= i_bus.act;
      r_regs_out <= r_regs;
      r_wr_stb   <= w_wr_ok;
      r_rd_stb   <= w_i2c_rd;
      if (w_wr_ok || w_i2c_rd) begin
        r_idx <= r_ptr;
      end
      // Rejected writes still advance the pointer; 8-bit wrap is natural.
      if (w_ptr_load) begin
        r_ptr <= i_bus.din;
      end else if (w_i2c_wr || w_i2c_rd) begin
        r_ptr <= r_ptr + 8'd1;
      end
      if (w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      // I2C write takes precedence over an application write to the same index.
      for (int k = 0; k < NREGS; k++) begin
        if (w_wr_ok && (r_ptr == 8'(k))) begin
          r_regs[8*k +: 8] <= i_bus.din;
        end else if (i_hw_we && (i_hw_addr == 8'(k))) begin
          r_regs[8*k +: 8] <= i_hw_wdata;
        end
      end
    end
  end

  assign o_regs_out = r_regs_out;
  assign o_wr_stb   = r_wr_stb;
  assign o_rd_stb   = r_rd_stb;
  assign o_idx_out  = r_idx;
  assign o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_i2c_regfile.sv
// Purpose : directed table-driven bench for i2c_regfile (NREGS=8, register 5 read-only).
// Latency : checks dout before the clock edge, strobes/counters 1 cycle after, regs_out 2 cycles after.
// Backpr. : not applicable; the bench paces every strobe.
module tb_i2c_regfile;
  localparam int          NR = 8;
  localparam logic [63:0] RV = 64'h7766_5544_3322_11A5;
  localparam logic [7:0]  RO = 8'b0010_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        hw_we;
  logic [7:0]  hw_addr;
  logic [7:0]  hw_wdata;
  logic [63:0] regs_out;
  logic        wr_stb;
  logic        rd_stb;
  logic [7:0]  idx_out;
  logic [7:0]  err_cnt;
  logic [7:0]  dout_pre;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_regfile_if bus ();

  i2c_regfile #(.NREGS(NR), .RST_VAL(RV), .RO_MASK(RO)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_bus      (bus),
    .i_hw_we    (hw_we),
    .i_hw_addr  (hw_addr),
    .i_hw_wdata (hw_wdata),
    .o_regs_out (regs_out),
    .o_wr_stb   (wr_stb),
    .o_rd_stb   (rd_stb),
    .o_idx_out  (idx_out),
    .o_err_cnt  (err_cnt)
  );

  typedef struct {
    logic       a, s_as, s_ws, s_rs;
    logic [7:0] din;
    logic       we;
    logic [7:0] ha, hd;
    logic       cd;
    logic [7:0] ed;
    logic       ewr, erd;
    logic [7:0] eidx, eerr;
    logic       cr;
    int         ri;
    logic [7:0] rv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic a, s_as, s_ws, s_rs, input logic [7:0] din,
                              input logic we, input logic [7:0] ha, hd,
                              input logic cd, input logic [7:0] ed,
                              input logic ewr, erd, input logic [7:0] eidx, eerr,
                              input logic cr, input int ri, input logic [7:0] rv);
    vec_t v;
    v.a = a; v.s_as = s_as; v.s_ws = s_ws; v.s_rs = s_rs; v.din = din;
    v.we = we; v.ha = ha; v.hd = hd; v.cd = cd; v.ed = ed;
    v.ewr = ewr; v.erd = erd; v.eidx = eidx; v.eerr = eerr;
    v.cr = cr; v.ri = ri; v.rv = rv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One bus cycle: inputs change at negedge, dout sampled before the edge,
  // registered outputs sampled just after it.
  task automatic drive(input logic a, s_as, s_ws, s_rs, input logic [7:0] din,
                       input logic we, input logic [7:0] ha, hd);
    @(negedge clk);
    bus.act = a; bus.as = s_as; bus.ws = s_ws; bus.rs = s_rs; bus.din = din;
    hw_we = we; hw_addr = ha; hw_wdata = hd;
    #1 dout_pre = bus.dout;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   wr_seen;

    //            a as ws rs din    we ha     hd     cd ed     wr rd idx    err    cr ri rv
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'hA5, 0,0,8'h00, 8'd0, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,1,8'h00, 0,8'h00,8'h00, 1,8'hA5, 0,1,8'h00, 8'd0, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h11, 0,0,8'h00, 8'd0, 0,0,8'h00));
    vecs.push_back(mk(0,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h11, 0,0,8'h00, 8'd0, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h11, 0,0,8'h00, 8'd0, 0,0,8'h00));
    vecs.push_back(mk(1,1,0,0,8'h02, 0,8'h00,8'h00, 1,8'h11, 0,0,8'h00, 8'd0, 0,0,8'h00));
    vecs.push_back(mk(1,0,1,0,8'h11, 0,8'h00,8'h00, 1,8'h22, 1,0,8'h02, 8'd0, 1,2,8'h22));
    vecs.push_back(mk(1,0,1,0,8'h22, 0,8'h00,8'h00, 1,8'h33, 1,0,8'h03, 8'd0, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h44, 0,0,8'h00, 8'd0, 1,2,8'h11));
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h44, 0,0,8'h00, 8'd0, 1,3,8'h22));
    vecs.push_back(mk(1,1,0,0,8'h05, 0,8'h00,8'h00, 1,8'h44, 0,0,8'h00, 8'd0, 0,0,8'h00));
    vecs.push_back(mk(1,0,1,0,8'h77, 0,8'h00,8'h00, 1,8'h55, 0,0,8'h00, 8'd1, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h66, 0,0,8'h00, 8'd1, 1,5,8'h55));
    vecs.push_back(mk(1,0,0,0,8'h00, 1,8'h05,8'h3C, 1,8'h66, 0,0,8'h00, 8'd1, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h66, 0,0,8'h00, 8'd1, 1,5,8'h3C));
    vecs.push_back(mk(1,1,0,0,8'h07, 0,8'h00,8'h00, 1,8'h66, 0,0,8'h00, 8'd1, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,1,8'h00, 0,8'h00,8'h00, 1,8'h77, 0,1,8'h07, 8'd1, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,1,8'h00, 0,8'h00,8'h00, 1,8'hFF, 0,1,8'h08, 8'd2, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'hFF, 0,0,8'h00, 8'd2, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,1,8'h00, 0,8'h00,8'h00, 1,8'hFF, 0,1,8'h09, 8'd3, 0,0,8'h00));
    vecs.push_back(mk(1,1,0,0,8'hFF, 0,8'h00,8'h00, 1,8'hFF, 0,0,8'h00, 8'd3, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,1,8'h00, 0,8'h00,8'h00, 1,8'hFF, 0,1,8'hFF, 8'd4, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'hA5, 0,0,8'h00, 8'd4, 0,0,8'h00));
    vecs.push_back(mk(1,1,0,0,8'h01, 0,8'h00,8'h00, 1,8'hA5, 0,0,8'h00, 8'd4, 0,0,8'h00));
    vecs.push_back(mk(1,0,1,0,8'hAA, 1,8'h01,8'h55, 1,8'h11, 1,0,8'h01, 8'd4, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h11, 0,0,8'h00, 8'd4, 1,1,8'hAA));
    vecs.push_back(mk(1,1,0,0,8'h01, 0,8'h00,8'h00, 1,8'h11, 0,0,8'h00, 8'd4, 0,0,8'h00));
    vecs.push_back(mk(1,0,1,0,8'hAA, 1,8'h04,8'h55, 1,8'hAA, 1,0,8'h01, 8'd4, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h11, 0,0,8'h00, 8'd4, 1,4,8'h55));
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h11, 0,0,8'h00, 8'd4, 1,1,8'hAA));
    vecs.push_back(mk(0,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h11, 0,0,8'h00, 8'd4, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h11, 0,0,8'h00, 8'd4, 0,0,8'h00));
    vecs.push_back(mk(1,0,1,0,8'h12, 0,8'h00,8'h00, 1,8'h11, 0,0,8'h00, 8'd5, 0,0,8'h00));
    vecs.push_back(mk(1,1,1,0,8'h03, 0,8'h00,8'h00, 1,8'h11, 0,0,8'h00, 8'd6, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h22, 0,0,8'h00, 8'd6, 0,0,8'h00));
    vecs.push_back(mk(1,1,0,0,8'h00, 0,8'h00,8'h00, 1,8'h22, 0,0,8'h00, 8'd6, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,1,8'h00, 0,8'h00,8'h00, 1,8'hA5, 0,1,8'h00, 8'd6, 0,0,8'h00));
    vecs.push_back(mk(1,0,0,0,8'h00, 1,8'h01,8'h99, 1,8'hAA, 0,0,8'h00, 8'd6, 0,0,8'h00));
`ifdef I2C_REGFILE_SNAPSHOT_EN
    vecs.push_back(mk(1,0,0,1,8'h00, 0,8'h00,8'h00, 1,8'hAA, 0,1,8'h01, 8'd6, 0,0,8'h00));
`else
    vecs.push_back(mk(1,0,0,1,8'h00, 0,8'h00,8'h00, 1,8'h99, 0,1,8'h01, 8'd6, 0,0,8'h00));
`endif
    vecs.push_back(mk(1,0,0,0,8'h00, 0,8'h00,8'h00, 1,8'h11, 0,0,8'h00, 8'd6, 1,1,8'h99));

    // Reset with the bus idle.
    rst = 1'b1;
    drive(0,0,0,0,8'h00, 0,8'h00,8'h00);
    drive(0,0,0,0,8'h00, 0,8'h00,8'h00);
    rst = 1'b0;
    chk("reset err_cnt",  err_cnt,  8'h00);
    chk("reset wr_stb",   wr_stb,   1'b0);
    chk("reset rd_stb",   rd_stb,   1'b0);
    chk("reset idx_out",  idx_out,  8'h00);
    chk("reset regs_out", regs_out, RV);
    chk("reset dout",     bus.dout, 8'hA5);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.a, v.s_as, v.s_ws, v.s_rs, v.din, v.we, v.ha, v.hd);
      if (v.cd) chk($sformatf("row%0d dout", i), dout_pre, v.ed);
      chk($sformatf("row%0d wr_stb", i), wr_stb, v.ewr);
      chk($sformatf("row%0d rd_stb", i), rd_stb, v.erd);
      if (v.ewr || v.erd) chk($sformatf("row%0d idx_out", i), idx_out, v.eidx);
      chk($sformatf("row%0d err_cnt", i), err_cnt, v.eerr);
      if (v.cr) chk($sformatf("row%0d regs_out[%0d]", i, v.ri), regs_out[v.ri*8 +: 8], v.rv);
    end

    // Data bytes with no pointer byte: every one is an error, counter saturates.
    drive(0,0,0,0,8'h00, 0,8'h00,8'h00);
    drive(1,0,0,0,8'h00, 0,8'h00,8'h00);
    wr_seen = 0;
    for (int n = 0; n < 255; n++) begin
      drive(1,0,1,0,8'h12, 0,8'h00,8'h00);
      if (wr_stb) wr_seen++;
    end
    chk("sat err_cnt", err_cnt, 8'hFF);
    chk("sat no wr_stb", wr_seen, 0);
    drive(1,0,1,0,8'h12, 0,8'h00,8'h00);
    chk("sat hold err_cnt", err_cnt, 8'hFF);

    // Reset in the middle of a write transfer.
    drive(1,1,0,0,8'h04, 0,8'h00,8'h00);
    drive(1,0,1,0,8'h5A, 0,8'h00,8'h00);
    chk("mid wr_stb", wr_stb, 1'b1);
    chk("mid idx_out", idx_out, 8'h04);
    rst = 1'b1;
    drive(1,0,0,0,8'h00, 0,8'h00,8'h00);
    rst = 1'b0;
    chk("rst2 err_cnt",  err_cnt,  8'h00);
    chk("rst2 regs_out", regs_out, RV);
    chk("rst2 dout",     bus.dout, 8'hA5);
    drive(0,0,0,0,8'h00, 0,8'h00,8'h00);
    drive(1,0,0,0,8'h00, 0,8'h00,8'h00);
    drive(1,0,0,1,8'h00, 0,8'h00,8'h00);
    chk("rst2 rd dout", dout_pre, 8'hA5);
    chk("rst2 rd_stb",  rd_stb,   1'b1);
    chk("rst2 idx_out", idx_out,  8'h00);
    drive(1,0,0,0,8'h00, 0,8'h00,8'h00);
    chk("rst2 ptr1 dout", dout_pre, 8'h11);
    chk("rst2 reg4", regs_out[39:32], 8'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
